hilo_muldiv_unit: RTL and testbench

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

---
 rtl/hilo_muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply-divide unit: iterative shift-add multiply and restoring divide.
// Define HILO_SIGNED_EN to run op 10/11 as signed MULT/DIV.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             hi_write,
    input  logic             lo_write,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             dz;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign b_zero = (b == '0);
    assign busy   = (state != IDLE);

`ifdef HILO_SIGNED_EN
    logic sgn_op;
    logic neg_res;
    logic neg_rem;

    assign sgn_op = op[1];
    assign a_mag  = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign b_mag  = (sgn_op && b[WIDTH-1]) ? -b : b;
`else
    logic unused_op;

    assign unused_op = op[1];
    assign a_mag     = a;
    assign b_mag     = b;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = (op[0] && b_zero) ? FINISH : RUN;
            RUN:     if (cnt == CW'(WIDTH-1)) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, (low[0] ? opa : {WIDTH{1'b0}})};
        shifted = {acc, low[WIDTH-1]};
        diff    = shifted - {1'b0, opa};
        prod    = {acc, low};
        res_hi  = acc;
        res_lo  = low;
        if (dz) begin
            res_hi = low;
            res_lo = '1;
        end else if (is_div) begin
`ifdef HILO_SIGNED_EN
            if (neg_rem) res_hi = -acc;
            if (neg_res) res_lo = -low;
`endif
        end else begin
`ifdef HILO_SIGNED_EN
            if (neg_res) prod = -prod;
`endif
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            dz       <= 1'b0;
            opa      <= '0;
            low      <= '0;
            acc      <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
`ifdef HILO_SIGNED_EN
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hi_write) hi_out <= hi_in;
                    if (lo_write) lo_out <= lo_in;
                    if (start) begin
                        cnt    <= '0;
                        acc    <= '0;
                        is_div <= op[0];
                        dz     <= op[0] && b_zero;
                        if (op[0]) begin
                            opa <= b_mag;
                            // divide-by-zero returns the raw dividend in HI
                            low <= b_zero ? a : a_mag;
                        end else begin
                            opa <= a_mag;
                            low <= b_mag;
                        end
`ifdef HILO_SIGNED_EN
                        neg_res <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem <= sgn_op && a[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc <= diff[WIDTH] ? shifted[WIDTH-1:0]
                                           : diff[WIDTH-1:0];
                        low <= {low[WIDTH-2:0], ~diff[WIDTH]};
                    end else begin
                        acc <= sum[WIDTH:1];
                        low <= {sum[0], low[WIDTH-1:1]};
                    end
                end
                FINISH: begin
                    hi_out   <= res_hi;
                    lo_out   <= res_lo;
                    done     <= 1'b1;
                    div_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit; the reference model follows
// HILO_SIGNED_EN so the same bench serves both builds.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi_in;
    logic [W-1:0] lo_in;
    logic         hi_write;
    logic         lo_write;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_in    (hi_in),
        .lo_in    (lo_in),
        .hi_write (hi_write),
        .lo_write (lo_write),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t e;
        logic sg;
        longint sx, sy, sp, sq, sr;
        longint unsigned ux, uy, up;
        sg = 1'b0;
`ifdef HILO_SIGNED_EN
        sg = o[1];
`endif
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        e.dz = 1'b0;
        if (!o[0]) begin
            if (sg) begin
                sp = sx * sy;
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end else begin
                up = ux * uy;
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
        end else if (y == '0) begin
            e.hi = x;
            e.lo = '1;
            e.dz = 1'b1;
        end else if (sg) begin
            sq = sx / sy;
            sr = sx % sy;
            e.hi = sr[31:0];
            e.lo = sq[31:0];
        end else begin
            up = ux / uy;
            e.lo = up[31:0];
            up = ux % uy;
            e.hi = up[31:0];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                check("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("hi", hi_out, mon_e.hi);
                check("lo", lo_out, mon_e.lo);
                check("div_zero", {63'd0, div_zero}, {63'd0, mon_e.dz});
                check("busy_with_done", {63'd0, busy}, 64'd0);
            end
        end else if (!reset && div_zero) begin
            check("stray_div_zero", {63'd0, div_zero}, 64'd0);
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        sbq.push_back(model(o, x, y));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat);
        int lat;
        lat = -1;
        for (int k = 1; k <= W + 10; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, exp_lat);
        if (lat > 0) begin
            @(posedge clk);
            #1 check("done_pulse_width", {63'd0, done}, 64'd0);
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
        issue(o, x, y);
        wait_done((o[0] && y == '0) ? 1 : W + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] h0, l0;
        exp_t e;
        reset = 1'b1;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        hi_in = '0;
        lo_in = '0;
        hi_write = 1'b0;
        lo_write = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_busy", {63'd0, busy}, 0);
        check("rst_done", {63'd0, done}, 0);
        check("rst_dz", {63'd0, div_zero}, 0);

        // first start on the first edge after release
        reset = 1'b0;
        op = 2'b00;
        a = '1;
        b = '1;
        start = 1'b1;
        sbq.push_back(model(2'b00, '1, '1));
        @(posedge clk);
        #1 start = 1'b0;
        check("first_start_busy", {63'd0, busy}, 1);
        wait_done(W + 1);
        check("multu_max_hi", hi_out, 32'hFFFFFFFE);
        check("multu_max_lo", lo_out, 32'h00000001);

        run(2'b01, 32'd100, 32'd7);
        check("divu_lo", lo_out, 32'd14);
        check("divu_hi", hi_out, 32'd2);
        run(2'b01, 32'h1234, 32'd0);
        check("div0_lo", lo_out, 32'hFFFFFFFF);
        run(2'b10, 32'hFFFFFFFD, 32'd5);
        run(2'b11, 32'hFFFFFFF9, 32'd2);
        run(2'b11, 32'h80000000, 32'hFFFFFFFF);
        run(2'b11, 32'h55, 32'd0);
        run(2'b00, 32'd0, 32'h12345678);
        run(2'b01, 32'd5, 32'd9);

        // direct writes in IDLE, independent enables
        h0 = hi_out;
        l0 = lo_out;
        @(negedge clk);
        hi_write = 1'b1;
        hi_in = 32'h0BAD_F00D;
        @(posedge clk);
        #1 hi_write = 1'b0;
        check("wr_hi", hi_out, 32'h0BAD_F00D);
        check("wr_hi_lo_kept", lo_out, l0);
        @(negedge clk);
        lo_write = 1'b1;
        lo_in = 32'hC0DE_1234;
        @(posedge clk);
        #1 lo_write = 1'b0;
        check("wr_lo", lo_out, 32'hC0DE_1234);
        check("wr_lo_hi_kept", hi_out, 32'h0BAD_F00D);

        // write and start in the same IDLE cycle
        @(negedge clk);
        hi_write = 1'b1;
        hi_in = 32'h5A5A5A5A;
        op = 2'b00;
        a = 32'd1000;
        b = 32'd3000;
        start = 1'b1;
        sbq.push_back(model(2'b00, 32'd1000, 32'd3000));
        @(posedge clk);
        #1 start = 1'b0;
        hi_write = 1'b0;
        check("wr_with_start", hi_out, 32'h5A5A5A5A);
        wait_done(W + 1);

        // write and start mid-RUN are ignored
        issue(2'b00, 32'h12345678, 32'h9ABCDEF0);
        h0 = hi_out;
        l0 = lo_out;
        repeat (5) @(posedge clk);
        @(negedge clk);
        hi_write = 1'b1;
        hi_in = 32'hAAAA5555;
        lo_write = 1'b1;
        lo_in = 32'h1111_2222;
        op = 2'b01;
        a = 32'd77;
        b = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hi_write = 1'b0;
        lo_write = 1'b0;
        check("run_hold_hi", hi_out, h0);
        check("run_hold_lo", lo_out, l0);
        wait_done(W + 1 - 6);
        repeat (W + 5) @(posedge clk);
        #1;
        e = model(2'b00, 32'h12345678, 32'h9ABCDEF0);
        check("only_first_hi", hi_out, e.hi);
        check("only_first_lo", lo_out, e.lo);

        // reset ten cycles into a divide
        issue(2'b01, 32'hDEADBEEF, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_hi", hi_out, 0);
        check("midrst_lo", lo_out, 0);
        check("midrst_busy", {63'd0, busy}, 0);
        check("midrst_done", {63'd0, done}, 0);
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        op = 2'b01;
        a = 32'd1000;
        b = 32'd33;
        start = 1'b1;
        sbq.push_back(model(2'b01, 32'd1000, 32'd33));
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(W + 1);

        for (int i = 0; i < 16; i++) begin
            logic [1:0] o;
            logic [W-1:0] x, y;
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            if (i[0]) y = y >> $urandom_range(0, 28);
            run(o, x, y);
        end

        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
